// File: rtl/csr_regfile_pkg.sv
// rtl/csr_regfile_pkg.sv - CSR numbers, field positions, writable masks and exception codes
package csr_regfile_pkg;

    typedef logic [13:0] csr_num_t;

    localparam csr_num_t CSR_CRMD   = 14'h000;
    localparam csr_num_t CSR_PRMD   = 14'h001;
    localparam csr_num_t CSR_ECFG   = 14'h004;
    localparam csr_num_t CSR_ESTAT  = 14'h005;
    localparam csr_num_t CSR_ERA    = 14'h006;
    localparam csr_num_t CSR_BADV   = 14'h007;
    localparam csr_num_t CSR_EENTRY = 14'h00C;
    localparam csr_num_t CSR_SAVE0  = 14'h030;
    localparam csr_num_t CSR_SAVE1  = 14'h031;
    localparam csr_num_t CSR_SAVE2  = 14'h032;
    localparam csr_num_t CSR_SAVE3  = 14'h033;
    localparam csr_num_t CSR_TID    = 14'h040;
    localparam csr_num_t CSR_TCFG   = 14'h041;
    localparam csr_num_t CSR_TVAL   = 14'h042;
    localparam csr_num_t CSR_TICLR  = 14'h044;

    localparam int CRMD_PLV_LSB    = 0;
    localparam int CRMD_IE         = 2;
    localparam int CRMD_DA         = 3;
    localparam int PRMD_PPLV_LSB   = 0;
    localparam int PRMD_PIE        = 2;
    localparam int ESTAT_HWI_LSB   = 2;
    localparam int ESTAT_TI        = 11;
    localparam int ESTAT_IPI       = 12;
    localparam int ESTAT_ECODE_LSB = 16;
    localparam int ESTAT_ESUB_LSB  = 22;
    localparam int TCFG_EN         = 0;
    localparam int TCFG_PERIODIC   = 1;
    localparam int TICLR_CLR       = 0;

    localparam logic [31:0] MASK_CRMD   = 32'h0000_000F;
    localparam logic [31:0] MASK_PRMD   = 32'h0000_0007;
    localparam logic [31:0] MASK_ECFG   = 32'h0000_1BFF;
    localparam logic [31:0] MASK_ESTAT  = 32'h0000_0003;
    localparam logic [31:0] MASK_EENTRY = 32'hFFFF_FFC0;
    localparam logic [31:0] MASK_ALL    = 32'hFFFF_FFFF;

    localparam logic [31:0] CRMD_RST = 32'h0000_0008;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_IPE  = 6'h0E;
    localparam logic [5:0] ECODE_FPD  = 6'h0F;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    function automatic logic [31:0] masked_merge(
        input logic [31:0] old_val,
        input logic [31:0] wdata,
        input logic [31:0] mask
    );
        return (old_val & ~mask) | (wdata & mask);
    endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// rtl/csr_regfile_if.sv - WB-stage CSR / exception interface between pipeline and CSR file
interface csr_regfile_if;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rvalue;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;

    modport master (
        output csr_num, csr_we, csr_wmask, csr_wdata,
        output wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
        output hw_int_in, ipi_int_in,
        input  csr_rvalue, has_int, ex_entry, ertn_entry
    );

    modport slave (
        input  csr_num, csr_we, csr_wmask, csr_wdata,
        input  wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
        input  hw_int_in, ipi_int_in,
        output csr_rvalue, has_int, ex_entry, ertn_entry
    );
endinterface

// File: rtl/csr_timer.sv
// rtl/csr_timer.sv - constant timer countdown (TVAL) and expiry pulse
module csr_timer
    import csr_regfile_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_tcfg,
    input  logic [29:0] i_init_new,
    input  logic        i_tcfg_we,
    output logic [31:0] o_tval,
    output logic        o_fire
);
    logic [31:0] r_tval;
    logic        w_en;
    logic [31:0] w_reload;

    assign w_en     = i_tcfg[TCFG_EN];
    assign w_reload = i_tcfg[TCFG_PERIODIC] ? {i_tcfg[31:2], 2'b00} : 32'hFFFF_FFFF;
    // A TCFG write restarts the count, so it also suppresses an expiry in that cycle.
    assign o_fire   = w_en && (r_tval == 32'h0) && !i_tcfg_we;
    assign o_tval   = r_tval;

    // One-shot expiry parks at all-ones, which the decrement guard never leaves.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tval <= 32'h0;
        end else if (i_tcfg_we) begin
            r_tval <= {i_init_new, 2'b00};
        end else if (o_fire) begin
            r_tval <= w_reload;
        end else if (w_en && (r_tval != 32'hFFFF_FFFF)) begin
            r_tval <= r_tval - 32'd1;
        end
    end
endmodule

// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - LoongArch control/status register file with exception, ertn and interrupt logic
module csr_regfile
    import csr_regfile_pkg::*;
#(
    parameter logic [31:0] TID_INIT   = 32'h0,
    parameter logic [31:0] EENTRY_RST = 32'h0
) (
    input  logic          clk,
    input  logic          reset,
    csr_regfile_if.slave  bus
);
    logic [31:0] r_crmd, r_prmd, r_ecfg, r_estat, r_era, r_badv, r_eentry, r_tid, r_tcfg;
    logic [31:0] r_save [4];

    logic [31:0] w_crmd_nx, w_prmd_nx, w_ecfg_nx, w_estat_nx, w_era_nx, w_badv_nx;
    logic [31:0] w_eentry_nx, w_tid_nx, w_tcfg_nx;
    logic [31:0] w_save_nx [4];

    logic [13:0] w_num;
    logic        w_we;
    logic [31:0] w_wmask, w_wdata, w_tval, w_rvalue;
    logic        w_tcfg_we, w_ticlr, w_timer_fire, w_badv_ex;

    assign w_num   = bus.csr_num;
    assign w_we    = bus.csr_we;
    assign w_wmask = bus.csr_wmask;
    assign w_wdata = bus.csr_wdata;

    function automatic logic [31:0] wr(
        input logic [31:0] old_val,
        input logic [13:0] num,
        input logic [31:0] fmask
    );
        return masked_merge(old_val, w_wdata,
                            (w_we && (w_num == num)) ? (w_wmask & fmask) : 32'h0);
    endfunction

    assign w_tcfg_we = w_we && (w_num == CSR_TCFG);
    assign w_ticlr   = w_we && (w_num == CSR_TICLR) && w_wmask[TICLR_CLR] && w_wdata[TICLR_CLR];
    assign w_tcfg_nx = wr(r_tcfg, CSR_TCFG, MASK_ALL);
    assign w_badv_ex = (bus.wb_ecode == ECODE_ADE) || (bus.wb_ecode == ECODE_ALE);

    csr_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_tcfg     (r_tcfg),
        .i_init_new (w_tcfg_nx[31:2]),
        .i_tcfg_we  (w_tcfg_we),
        .o_tval     (w_tval),
        .o_fire     (w_timer_fire)
    );

    // Software writes first, then exception/ertn overwrite only the fields they own.
    always_comb begin
        w_crmd_nx   = wr(r_crmd,   CSR_CRMD,   MASK_CRMD);
        w_prmd_nx   = wr(r_prmd,   CSR_PRMD,   MASK_PRMD);
        w_ecfg_nx   = wr(r_ecfg,   CSR_ECFG,   MASK_ECFG);
        w_estat_nx  = wr(r_estat,  CSR_ESTAT,  MASK_ESTAT);
        w_era_nx    = wr(r_era,    CSR_ERA,    MASK_ALL);
        w_badv_nx   = wr(r_badv,   CSR_BADV,   MASK_ALL);
        w_eentry_nx = wr(r_eentry, CSR_EENTRY, MASK_EENTRY);
        w_tid_nx    = wr(r_tid,    CSR_TID,    MASK_ALL);
        for (int i = 0; i < 4; i++) begin
            w_save_nx[i] = wr(r_save[i], CSR_SAVE0 + 14'(i), MASK_ALL);
        end

        w_estat_nx[ESTAT_HWI_LSB +: 8] = bus.hw_int_in;
        w_estat_nx[ESTAT_IPI]          = bus.ipi_int_in;
        if (w_timer_fire) begin
            w_estat_nx[ESTAT_TI] = 1'b1;
        end else if (w_ticlr) begin
            w_estat_nx[ESTAT_TI] = 1'b0;
        end

        if (bus.wb_ex) begin
            w_prmd_nx[PRMD_PPLV_LSB +: 2]    = r_crmd[CRMD_PLV_LSB +: 2];
            w_prmd_nx[PRMD_PIE]              = r_crmd[CRMD_IE];
            w_crmd_nx[CRMD_PLV_LSB +: 2]     = 2'b00;
            w_crmd_nx[CRMD_IE]               = 1'b0;
            w_estat_nx[ESTAT_ECODE_LSB +: 6] = bus.wb_ecode;
            w_estat_nx[ESTAT_ESUB_LSB +: 9]  = bus.wb_esubcode;
            w_era_nx                         = bus.wb_pc;
            if (w_badv_ex) begin
                w_badv_nx = bus.wb_vaddr;
            end
        end else if (bus.ertn_flush) begin
            w_crmd_nx[CRMD_PLV_LSB +: 2] = r_prmd[PRMD_PPLV_LSB +: 2];
            w_crmd_nx[CRMD_IE]           = r_prmd[PRMD_PIE];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_crmd   <= CRMD_RST;
            r_prmd   <= 32'h0;
            r_ecfg   <= 32'h0;
            r_estat  <= 32'h0;
            r_era    <= 32'h0;
            r_badv   <= 32'h0;
            r_eentry <= EENTRY_RST;
            r_tid    <= TID_INIT;
            r_tcfg   <= 32'h0;
            for (int i = 0; i < 4; i++) begin
                r_save[i] <= 32'h0;
            end
        end else begin
            r_crmd   <= w_crmd_nx;
            r_prmd   <= w_prmd_nx;
            r_ecfg   <= w_ecfg_nx;
            r_estat  <= w_estat_nx;
            r_era    <= w_era_nx;
            r_badv   <= w_badv_nx;
            r_eentry <= w_eentry_nx;
            r_tid    <= w_tid_nx;
            r_tcfg   <= w_tcfg_nx;
            for (int i = 0; i < 4; i++) begin
                r_save[i] <= w_save_nx[i];
            end
        end
    end

    always_comb begin
        w_rvalue = 32'h0;
        case (w_num)
            CSR_CRMD:   w_rvalue = r_crmd;
            CSR_PRMD:   w_rvalue = r_prmd;
            CSR_ECFG:   w_rvalue = r_ecfg;
            CSR_ESTAT:  w_rvalue = r_estat;
            CSR_ERA:    w_rvalue = r_era;
            CSR_BADV:   w_rvalue = r_badv;
            CSR_EENTRY: w_rvalue = r_eentry;
            CSR_SAVE0:  w_rvalue = r_save[0];
            CSR_SAVE1:  w_rvalue = r_save[1];
            CSR_SAVE2:  w_rvalue = r_save[2];
            CSR_SAVE3:  w_rvalue = r_save[3];
            CSR_TID:    w_rvalue = r_tid;
            CSR_TCFG:   w_rvalue = r_tcfg;
            CSR_TVAL:   w_rvalue = w_tval;
            default:    w_rvalue = 32'h0;
        endcase
    end

    assign bus.csr_rvalue = w_rvalue;
    assign bus.has_int    = r_crmd[CRMD_IE] && (|(r_estat[12:0] & r_ecfg[12:0]));
    assign bus.ex_entry   = r_eentry;
    assign bus.ertn_entry = r_era;
endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
- Control/status register file for the LoongArch pipeline; the responder on the WB-stage CSR/exception interface.
- Services WB's CSR read, masked write, exception commit (wb_ex/ecode/esubcode/vaddr/pc) and ertn.
- Returns read data the same cycle, plus exception entry, return PC and the interrupt request that IF/ID consume.
- Owns the constant timer (TCFG/TVAL/TICLR) and the interrupt-pending logic.

Parameters:
- TID_INIT, 32'h0, reset value of the TID register.
- EENTRY_RST, 32'h0, reset value of EENTRY.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- csr_num  in  14  CSR address, for both read and write
- csr_we  in  1  write strobe; already qualified by WB valid
- csr_wmask  in  32  per-bit write mask
- csr_wdata  in  32  write data
- csr_rvalue  out  32  combinational read data for csr_num
- wb_ex  in  1  exception commits this cycle
- wb_ecode  in  6  exception code
- wb_esubcode  in  9  exception sub-code
- wb_pc  in  32  PC of the excepting instruction
- wb_vaddr  in  32  faulting address
- ertn_flush  in  1  ertn commits this cycle
- hw_int_in  in  8  hardware interrupt lines (level)
- ipi_int_in  in  1  inter-processor interrupt (level)
- has_int  out  1  interrupt pending and enabled
- ex_entry  out  32  exception entry = EENTRY
- ertn_entry  out  32  return PC = ERA

Behaviour:
- Implemented CSRs (num / writable fields):
  - CRMD 0x0 (PLV[1:0], IE[2], DA[3])
  - PRMD 0x1 (PPLV[1:0], PIE[2])
  - ECFG 0x4 (LIE[12:0], bit 10 reserved = 0)
  - ESTAT 0x5 (IS[1:0] only; IS[9:2], IS[11], IS[12], Ecode[21:16], EsubCode[30:22] read-only)
  - ERA 0x6, BADV 0x7, EENTRY 0xC (VA[31:6] writable, [5:0] = 0)
  - SAVE0–3 0x30–0x33, TID 0x40
  - TCFG 0x41 (En[0], Periodic[1], InitVal[31:2])
  - TVAL 0x42 (read-only)
  - TICLR 0x44 (reads 0; CLR[0] write-1)
- Reset (synchronous, single cycle):
  - CRMD = 32'h8 (DA = 1).
  - EENTRY = EENTRY_RST, TID = TID_INIT.
  - All other registers 0; has_int = 0.
  - Reset mid-operation discards any in-flight write or timer state.
- Read: csr_rvalue = mux(csr_num), zero latency. Unimplemented numbers read 0. Read reflects the pre-write value in a cycle with a same-register write.
- Write: reg <= (reg & ~(wmask & FIELDMASK)) | (wdata & wmask & FIELDMASK). Effective next cycle.
- Exception (wb_ex = 1):
  - PRMD.PPLV <= CRMD.PLV, PRMD.PIE <= CRMD.IE.
  - CRMD.PLV <= 0, CRMD.IE <= 0.
  - ESTAT.Ecode/EsubCode <= wb_ecode/wb_esubcode.
  - ERA <= wb_pc.
  - BADV <= wb_vaddr only for ecode ADE (0x08) or ALE (0x09).
- ertn (ertn_flush = 1, wb_ex = 0): CRMD.PLV <= PRMD.PPLV, CRMD.IE <= PRMD.PIE.
- Priority on the same register field: wb_ex > ertn_flush > csr_we. Fields not touched by wb_ex/ertn still take the csr_we update.
- Interrupt sampling:
  - ESTAT.IS[9:2] <= hw_int_in every cycle.
  - IS[12] <= ipi_int_in every cycle.
- Timer:
  - TCFG write: TVAL <= {new InitVal, 2'b00} next cycle; this overrides countdown.
  - Else if En && TVAL == 0: IS[11] <= 1; TVAL <= Periodic ? {InitVal, 2'b00} : 32'hFFFF_FFFF.
  - Else if En && TVAL != 32'hFFFF_FFFF: TVAL <= TVAL − 1.
  - One-shot expiry therefore parks at FFFF_FFFF and never re-fires. En = 0 freezes TVAL.
- TICLR: write with wdata[0] & wmask[0] clears IS[11]. A timer fire in the same cycle wins, so IS[11] stays 1.
- has_int = CRMD.IE && |(ESTAT.IS[12:0] & ECFG.LIE[12:0]), combinational from registers.

Decomposition:
- Extend the shared define.v with:
  - CSR number constants (CSR_CRMD … CSR_TICLR).
  - Field bit-position constants.
  - Per-CSR writable FIELDMASK constants.
  - ECODE_ADE/ALE and the other ECODE constants, reusing the existing ones.
- One sub-module, csr_timer.
  - Inputs: TCFG value, tcfg write pulse.
  - Outputs: TVAL, timer-fire pulse.
  - Parent owns IS[11].

Test Plan:
- Reset, then read 0x0 → 32'h8. Write SAVE0 wdata = FFFF_FFFF, wmask = 0000_FFFF after SAVE0 = 1234_5678 → read 1234_FFFF. Read 0x99 → 0.
- CRMD = 32'h7, wb_ex with ecode 0x09, wb_pc = 1C00_0100, wb_vaddr = 0000_0003:
  - next cycle CRMD[2:0] = 0, PRMD[2:0] = 3'b111, ERA = 1C00_0100, BADV = 3, ESTAT[21:16] = 0x09.
  - Then ertn_flush → CRMD[2:0] = 3'b111.
- wb_ex and csr_we to ERA (wdata = DEAD_BEEF) in the same cycle → ERA = wb_pc.
- TCFG write InitVal → TVAL = 8, En = 1, Periodic = 0:
  - TVAL counts 8…0; IS[11] = 1 at the cycle after TVAL = 0; TVAL then stays FFFF_FFFF.
  - Write TICLR = 1 → IS[11] = 0.
- Periodic, TVAL = 4: fires every 5 cycles. TICLR in the fire cycle → IS[11] remains 1.
- ECFG.LIE[2] = 1, CRMD.IE = 1, hw_int_in = 8'h01 → has_int = 1 one cycle later. IE = 0 → has_int = 0.
